generador_aleatorio: RTL and testbench

GENERADOR_ALEATORIO -- requirements
Module: generador_aleatorio

---
 rtl/generador_aleatorio_pkg.sv | 27 ++
 rtl/fifo_valores.sv | 70 +++++++
 rtl/generador_aleatorio.sv | 92 +++++++++
 tb/tb_generador_aleatorio.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/generador_aleatorio_pkg.sv
`default_nettype none
// ============================================================================
// Module   : generador_aleatorio_pkg
// Brief    : Shared constants for the random generator: Galois tap masks and
//            the default seed.
// Revision : 1.0
// ============================================================================
package generador_aleatorio_pkg;

    localparam logic [31:0] c_default_seed = 32'h0000_ACE1;

    // Right-shifting Galois tap masks for the supported LFSR widths.
    function automatic logic [31:0] taps_for(input int width);
        logic [31:0] taps;
        taps = 32'h0;
        case (width)
            4:       taps = 32'h0000_0009;
            8:       taps = 32'h0000_00B8;
            16:      taps = 32'h0000_B400;
            32:      taps = 32'hA300_0000;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_valores.sv
`default_nettype none
// ============================================================================
// Module   : fifo_valores
// Brief    : Power-of-two circular buffer holding generated values, with
//            synchronous flush and registered head output.
// Revision : 1.0
// ============================================================================
module fifo_valores #(
    parameter int WIDTH = 5,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty
);

    localparam int c_aw = $clog2(DEPTH);
    localparam int c_cw = $clog2(DEPTH + 1);
    localparam logic [c_cw-1:0] c_depth_cnt = c_cw'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr_ptr;
    logic [c_aw-1:0]  r_rd_ptr;
    logic [c_cw-1:0]  r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign empty = (r_count == '0);
    assign full  = (r_count == c_depth_cnt);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    // A pop on an empty buffer is ignored; a full buffer accepts a push only
    // when the same-cycle pop frees the slot.
    assign w_do_pop  = pop && !empty && !flush;
    assign w_do_push = push && (!full || w_do_pop) && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= din;
    end

endmodule
`default_nettype wire

// File: rtl/generador_aleatorio.sv
`default_nettype none
// ============================================================================
// Module   : generador_aleatorio
// Brief    : Galois LFSR random source with optional repeat suppression,
//            feeding a small output buffer read with a ready handshake.
// Revision : 1.0
// ============================================================================
module generador_aleatorio
    import generador_aleatorio_pkg::*;
#(
    parameter int          LFSR_W = 16,
    parameter int          OUT_W  = 5,
    parameter int          DEPTH  = 4,
    parameter logic [31:0] SEED   = c_default_seed
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       seed_load,
    input  logic [LFSR_W-1:0]          seed,
    input  logic                       no_repeat,
    input  logic                       rd_ready,
    output logic [OUT_W-1:0]           rand_out,
    output logic                       rand_valid,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full
);

    localparam logic [LFSR_W-1:0] c_taps = LFSR_W'(taps_for(LFSR_W));
    localparam logic [LFSR_W-1:0] c_seed = LFSR_W'(SEED);

    logic [LFSR_W-1:0] r_lfsr;
    logic [OUT_W-1:0]  r_last_val;
    logic              r_last_valid;

    logic [LFSR_W-1:0] w_next;
    logic [OUT_W-1:0]  w_cand;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_step;
    logic              w_drop;
    logic              w_push;

    assign w_next = r_lfsr[0] ? ((r_lfsr >> 1) ^ c_taps) : (r_lfsr >> 1);
    assign w_cand = w_next[OUT_W-1:0];

    // seed_load overrides both generation and consumption for its cycle.
    assign w_pop  = !w_empty && rd_ready && !seed_load;
    assign w_step = en && !seed_load && (!w_full || w_pop);
    assign w_drop = no_repeat && r_last_valid && (w_cand == r_last_val);
    assign w_push = w_step && !w_drop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_lfsr       <= c_seed;
            r_last_val   <= '0;
            r_last_valid <= 1'b0;
        end else if (seed_load) begin
            // A zero seed would lock the register, so fall back to the default.
            r_lfsr       <= (seed == '0) ? c_seed : seed;
            r_last_valid <= 1'b0;
        end else begin
            if (w_step) r_lfsr <= w_next;
            if (w_push) begin
                r_last_val   <= w_cand;
                r_last_valid <= 1'b1;
            end
        end
    end

    fifo_valores #(
        .WIDTH (OUT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .flush (seed_load),
        .push  (w_push),
        .pop   (w_pop),
        .din   (w_cand),
        .dout  (rand_out),
        .count (count),
        .full  (w_full),
        .empty (w_empty)
    );

    assign rand_valid = !w_empty;
    assign full       = w_full;

endmodule
`default_nettype wire

// File: tb/tb_generador_aleatorio.sv
`default_nettype none
// ============================================================================
// Module   : tb_generador_aleatorio
// Brief    : Scoreboard bench for generador_aleatorio (16-bit and 4-bit LFSR).
// Revision : 1.0
// ============================================================================
module tb_generador_aleatorio;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, en, seed_load, no_repeat, rd_ready;
    logic [15:0] seed;
    logic [4:0]  rand_out;
    logic        rand_valid, full;
    logic [2:0]  count;

    logic        en4, sl4, nr4, rd4;
    logic [3:0]  seed4, out4;
    logic        v4, full4;
    logic [2:0]  count4;

    generador_aleatorio dut (
        .clk(clk), .rst(rst), .en(en), .seed_load(seed_load), .seed(seed),
        .no_repeat(no_repeat), .rd_ready(rd_ready), .rand_out(rand_out),
        .rand_valid(rand_valid), .count(count), .full(full)
    );

    generador_aleatorio #(.LFSR_W(4), .OUT_W(4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .seed_load(sl4), .seed(seed4),
        .no_repeat(nr4), .rd_ready(rd4), .rand_out(out4),
        .rand_valid(v4), .count(count4), .full(full4)
    );

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];
    logic [3:0] exp4_q[$];

    bit         nr_mode = 1'b0;
    bit         have_prev = 1'b0;
    logic [4:0] prev;
    int         reps = 0;
    int         npops = 0;

    // Hand-derived outputs from seed 0xACE1 (lfsr E270,7138,389C,1C4E,0E27,...)
    logic [4:0] seq16 [10] = '{5'd16, 5'd24, 5'd28, 5'd14, 5'd7,
                               5'd19, 5'd9,  5'd4,  5'd2,  5'd17};
    // 4-bit LFSR from seed 1 with taps 0x9: period 15
    logic [3:0] seq4 [15] = '{4'h9, 4'hD, 4'hF, 4'hE, 4'h7, 4'hA, 4'h5, 4'hB,
                              4'hC, 4'h6, 4'h3, 4'h8, 4'h4, 4'h2, 4'h1};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        rd_ready = 1'b1;
        while ((count != 3'd0 || exp_q.size() != 0) && n < 50) begin
            tick();
            n++;
        end
        if (n >= 50) begin
            errors++; checks++;
            $display("FAIL %s_drain_timeout actual=%0d required=0", name, count);
        end
        rd_ready = 1'b0;
    endtask

    function automatic logic [15:0] step16(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hB400) : (s >> 1);
    endfunction

    // Scoreboard monitors: a pop happens at the edge following a sample with
    // valid and ready both high.
    initial forever begin
        @(negedge clk);
        if (rst === 1'b0 && seed_load !== 1'b1 && rand_valid === 1'b1 && rd_ready === 1'b1) begin
            npops++;
            if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_value actual=%0d required=none", rand_out);
            end else begin
                check("rand_out", rand_out, exp_q.pop_front());
            end
            if (have_prev) begin
                if (nr_mode) check("no_consecutive_repeat", (rand_out == prev), 0);
                if (rand_out == prev) reps++;
            end
            prev = rand_out;
            have_prev = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        if (rst === 1'b0 && v4 === 1'b1 && rd4 === 1'b1) begin
            check("out4_nonzero", (out4 != 4'd0), 1);
            if (exp4_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL unexpected_value4 actual=%0d required=none", out4);
            end else begin
                check("rand_out4", out4, exp4_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [15:0] m;
        logic [4:0]  lval, cand;
        bit          lv;
        int          idx;

        rst = 1'b1; en = 0; seed_load = 0; seed = '0; no_repeat = 0; rd_ready = 0;
        en4 = 0; sl4 = 0; nr4 = 0; rd4 = 0; seed4 = '0;
        tick(); tick();
        check("rst_count", count, 0);
        check("rst_valid", rand_valid, 0);
        check("rst_full", full, 0);
        rst = 1'b0;

        // Idle with en low
        for (int i = 0; i < 20; i++) begin
            tick();
            check("idle_valid", rand_valid, 0);
            check("idle_count", count, 0);
            check("idle_full", full, 0);
        end

        // First two values from default seed
        en = 1'b1; exp_q.push_back(5'd16); tick();
        exp_q.push_back(5'd24); tick();
        en = 1'b0;
        check("two_count", count, 2);
        drain("first_two");

        // Fill to 3, then seed_load with seed=0 falls back to default seed
        en = 1'b1;
        exp_q.push_back(5'd28); tick();
        exp_q.push_back(5'd14); tick();
        exp_q.push_back(5'd7);  tick();
        en = 1'b0;
        check("three_count", count, 3);
        seed_load = 1'b1; seed = 16'h0000; tick();
        seed_load = 1'b0;
        exp_q.delete();
        check("flush_count", count, 0);
        check("flush_valid", rand_valid, 0);
        en = 1'b1; exp_q.push_back(5'd16); tick();
        exp_q.push_back(5'd24); tick();
        en = 1'b0;
        drain("after_seed0");

        // Asynchronous reset mid-operation
        en = 1'b1;
        exp_q.push_back(5'd28); tick();
        exp_q.push_back(5'd14); tick();
        en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("async_rst_count", count, 0);
        check("async_rst_valid", rand_valid, 0);
        exp_q.delete();
        tick();
        rst = 1'b0;
        en = 1'b1; exp_q.push_back(5'd16); tick();
        exp_q.push_back(5'd24); tick();
        en = 1'b0;
        drain("after_reset");

        // Fill to full with explicit seed load, then push+pop at full
        seed_load = 1'b1; seed = 16'hACE1; tick();
        seed_load = 1'b0;
        idx = 0;
        en = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (i < 4) begin
                exp_q.push_back(seq16[idx]);
                idx++;
            end
            tick();
            check("fill_count", count, (i < 3) ? i + 1 : 4);
        end
        check("full_flag", full, 1);
        rd_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            exp_q.push_back(seq16[idx]);
            idx++;
            tick();
            check("full_pushpop_count", count, 4);
        end
        en = 1'b0;
        drain("full_phase");

        // 4-bit LFSR period
        rd4 = 1'b1; en4 = 1'b1;
        for (int i = 0; i < 30; i++) begin
            exp4_q.push_back(seq4[i % 15]);
            tick();
        end
        en4 = 1'b0;
        for (int n = 0; n < 20 && (exp4_q.size() != 0 || count4 != 3'd0); n++) tick();
        check("lfsr4_drained", exp4_q.size(), 0);
        rd4 = 1'b0;

        // no_repeat on and off over long runs
        for (int pass = 0; pass < 2; pass++) begin
            seed_load = 1'b1; seed = 16'hACE1; tick();
            seed_load = 1'b0;
            m = 16'hACE1; lv = 1'b0; lval = '0;
            nr_mode = (pass == 0);
            no_repeat = (pass == 0);
            have_prev = 1'b0; reps = 0; npops = 0;
            en = 1'b1; rd_ready = 1'b1;
            for (int i = 0; i < 2100; i++) begin
                m = step16(m);
                cand = m[4:0];
                if (!(no_repeat && lv && cand == lval)) begin
                    exp_q.push_back(cand);
                    lval = cand;
                    lv = 1'b1;
                end
                tick();
            end
            en = 1'b0;
            drain("long_run");
            check("pop_total_ge_2000", (npops >= 2000), 1);
            if (pass == 1) check("repeat_seen_without_filter", (reps > 0), 1);
            nr_mode = 1'b0;
            no_repeat = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
